ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-port RAM front end that sits directly upstream of the 512x16 `ram_tst` block RAM. It arbitrates one write stream (the data loader) and one read stream (the display/LED reader) onto the RAM's single address/data/write-enable port. Writes have priority, and a burst limiter guarantees the reader is never starved. It also returns read data with a fixed, documented latency and counts accepted writes.

## Interface
Parameters:
- ADDR_W, 9, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM read latency in cycles from registered address to valid `ram_dout` (1 or 2)
- MAX_WR_BURST, 4, max consecutive write grants while a read is pending (1..15)

Ports:
- CLK  in  1  system clock; every register is on posedge CLK
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle (combinational)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req  in  1  read request
- rd_ack  out  1  read accepted this cycle (combinational)
- rd_addr  in  ADDR_W  read address
- rd_valid  out  1  read data valid pulse
- rd_data  out  DATA_W  read data; meaningful only while rd_valid=1
- wr_count  out  8  saturating count of accepted writes
- ram_addr  out  ADDR_W  to RAM addra (registered)
- ram_din  out  DATA_W  to RAM dina (registered)
- ram_we  out  1  to RAM wea (registered)
- ram_dout  in  DATA_W  from RAM douta

## Operation
- Grant logic is evaluated every cycle, in this order:
  - read_grant = rd_req & (!wr_valid | burst_cnt >= MAX_WR_BURST).
  - write_grant = wr_valid & !read_grant.
- wr_ready = write_grant and rd_ack = read_grant. They are never both 1.
- The grants depend combinationally on wr_valid and rd_req. Requesters must not make valid/req depend on ready/ack.
- A transfer happens when valid/req and ready/ack are both 1. A requester holds its addr/data stable until the transfer.
- burst_cnt (4 bit):
  - +1 on a write grant while rd_req=1.
  - Cleared on a read grant, or on any cycle with rd_req=0.
  - Saturates at MAX_WR_BURST.
- RAM port registers, updated each edge:
  - Write grant: ram_addr<=wr_addr, ram_din<=wr_data, ram_we<=1.
  - Read grant: ram_addr<=rd_addr, ram_we<=0, ram_din holds.
  - No grant: ram_we<=0, ram_addr and ram_din hold.
- Read return pipeline: shift register of depth RD_LAT+1 carrying the read-grant flag. rd_valid is the last stage. rd_data = ram_dout, passed through combinationally.
- Reads are in order with at most one per cycle. Back-to-back reads return back-to-back rd_valid pulses.
- RAM write mode is irrelevant: ram_dout is never sampled in cycles where no read returns.
- A read of an address written by an earlier transfer returns the new data. The registered RAM port serialises both accesses in grant order.
- wr_count increments on each write transfer and saturates at 255.

## Timing
- Read handshake in cycle T:
  - ram_addr is valid in T+1.
  - rd_valid=1 with correct rd_data in T+1+RD_LAT (latency 2 cycles at RD_LAT=1).
- Write handshake in cycle T: ram_we=1 with ram_addr/ram_din in T+1. The RAM commits at the end of T+1.
- Sustained throughput is one access per cycle.
- With both streams continuously requesting, the pattern is MAX_WR_BURST writes, then 1 read, repeating.
- Reset (synchronous, takes effect at the edge where rst=1):
  - Cleared: ram_we, ram_addr, ram_din, burst_cnt, wr_count, the whole read pipeline, and therefore rd_valid.
  - wr_ready and rd_ack are forced to 0 while rst=1.
- Reset mid-operation: reads that were issued but not yet returned are dropped (no rd_valid after reset). A write registered but not yet committed may or may not land in the RAM. The testbench must not check that address.
- After rst deasserts, the first grant is possible in the same cycle.

## Test plan
- Reset: hold rst 3 cycles with wr_valid=rd_req=1 -> wr_ready=rd_ack=0, ram_we=0, rd_valid=0, wr_count=0.
- Load then read: write 0x0001, 0x0010, 0x0100, 0x1000 to addresses 0..3 on consecutive cycles, then read addresses 0..3 back to back -> four consecutive rd_valid pulses carrying those values in order, the first 2 cycles after the first rd_ack (RD_LAT=1); wr_count=4.
- Priority / anti-starvation: hold wr_valid=1 and rd_req=1 continuously with MAX_WR_BURST=4 -> grant pattern W,W,W,W,R repeating; no read waits more than 5 cycles.
- Read-after-write: write 0xBEEF to address 0x1FF, then read 0x1FF in the next cycle -> rd_data=0xBEEF.
- Reset mid-read: issue a read, assert rst in the next cycle -> no rd_valid within RD_LAT+3 cycles; a subsequent read of address 0 returns the RAM contents normally.
- Saturation: perform 300 writes -> wr_count stays at 255.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Front end for a single-port block RAM. It arbitrates one write stream and one
// read stream onto the RAM's single registered address/data/write-enable port.
// Writes have priority. A burst limiter hands the port to a pending read after
// MAX_WR_BURST consecutive writes. Read data comes back after a fixed latency of
// 1 + RD_LAT cycles, and the block keeps a saturating count of accepted writes.
//
// Ports:
//   CLK, rst            clock; synchronous active-high reset
//   wr_valid/wr_ready   write handshake; wr_ready is combinational
//   wr_addr, wr_data    write address/data, held by the writer until accepted
//   rd_req/rd_ack       read handshake; rd_ack is combinational
//   rd_addr             read address, held by the reader until accepted
//   rd_valid, rd_data   read return; rd_data is meaningful only with rd_valid
//   wr_count            saturating (255) count of accepted writes
//   ram_addr/din/we     registered RAM port outputs
//   ram_dout            RAM read data
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned MAX_WR_BURST = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        wr_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [3:0] MaxBurst = 4'(MAX_WR_BURST);

  logic [3:0]      burst_cnt;
  logic            read_grant;
  logic            write_grant;
  // Bit 0 is set the cycle after a read grant; the top bit lines up with ram_dout.
  logic [RD_LAT:0] rd_pipe;

  // Reads win only when the writer is idle or has used up its burst allowance.
  always_comb begin
    read_grant  = !rst && rd_req && (!wr_valid || (burst_cnt >= MaxBurst));
    write_grant = !rst && wr_valid && !read_grant;
  end

  assign wr_ready = write_grant;
  assign rd_ack   = read_grant;
  assign rd_valid = rd_pipe[RD_LAT];
  assign rd_data  = ram_dout;

  always_ff @(posedge CLK) begin
    if (rst) begin
      burst_cnt <= '0;
      wr_count  <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      rd_pipe   <= '0;
    end else begin
      // Burst count only means something while a read is waiting.
      if (read_grant || !rd_req) begin
        burst_cnt <= '0;
      end else if (write_grant && (burst_cnt < MaxBurst)) begin
        burst_cnt <= burst_cnt + 4'd1;
      end

      ram_we <= write_grant;
      if (write_grant) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end else if (read_grant) begin
        ram_addr <= rd_addr;
      end

      rd_pipe <= {rd_pipe[RD_LAT-1:0], read_grant};

      if (write_grant && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic        CLK = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, rd_req, rd_ack, rd_valid, ram_we;
  logic [8:0]  wr_addr, rd_addr, ram_addr;
  logic [15:0] wr_data, rd_data, ram_din, ram_dout;
  logic [7:0]  wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(
    .ADDR_W(9), .DATA_W(16), .RD_LAT(1), .MAX_WR_BURST(4)
  ) dut (
    .CLK(CLK), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_count(wr_count),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // 512x16 single-port RAM, one cycle read latency.
  logic [15:0] mem [512];
  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wv;
    logic [8:0]  wa;
    logic [15:0] wd;
    logic        rr;
    logic [8:0]  ra;
    logic        e_wr;
    logic        e_rd;
    logic        e_we;
    logic        e_val;
    logic [15:0] e_data;
  } vec_t;

  localparam int NVec = 27;
  vec_t vecs [NVec];

  function automatic vec_t mk(logic wv, logic [8:0] wa, logic [15:0] wd, logic rr,
                              logic [8:0] ra, logic e_wr, logic e_rd, logic e_we,
                              logic e_val, logic [15:0] e_data);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rr = rr; v.ra = ra;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_we = e_we; v.e_val = e_val; v.e_data = e_data;
    return v;
  endfunction

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge CLK); #1;
      rst = 1'b0;
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_req = vecs[i].rr; rd_addr = vecs[i].ra;
      @(negedge CLK);
      chk($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].e_wr);
      chk($sformatf("v%0d_rd_ack", i), rd_ack, vecs[i].e_rd);
      chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].e_val);
      if (vecs[i].e_val) chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1'b1; wr_valid = 1'b1; rd_req = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Load 0..3 then read back to back: data returns two cycles after each ack.
    vecs[0]  = mk(1, 9'h000, 16'h0001, 0, 9'h000, 1, 0, 0, 0, 16'h0);
    vecs[1]  = mk(1, 9'h001, 16'h0010, 0, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[2]  = mk(1, 9'h002, 16'h0100, 0, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[3]  = mk(1, 9'h003, 16'h1000, 0, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[4]  = mk(0, 9'h000, 16'h0000, 1, 9'h000, 0, 1, 1, 0, 16'h0);
    vecs[5]  = mk(0, 9'h000, 16'h0000, 1, 9'h001, 0, 1, 0, 0, 16'h0);
    vecs[6]  = mk(0, 9'h000, 16'h0000, 1, 9'h002, 0, 1, 0, 1, 16'h0001);
    vecs[7]  = mk(0, 9'h000, 16'h0000, 1, 9'h003, 0, 1, 0, 1, 16'h0010);
    vecs[8]  = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 1, 16'h0100);
    vecs[9]  = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 1, 16'h1000);
    vecs[10] = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 0, 16'h0);
    // Both streams busy: W W W W R W W W W R.
    vecs[11] = mk(1, 9'h020, 16'hA000, 1, 9'h000, 1, 0, 0, 0, 16'h0);
    vecs[12] = mk(1, 9'h021, 16'hA001, 1, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[13] = mk(1, 9'h022, 16'hA002, 1, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[14] = mk(1, 9'h023, 16'hA003, 1, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[15] = mk(1, 9'h024, 16'hA004, 1, 9'h000, 0, 1, 1, 0, 16'h0);
    vecs[16] = mk(1, 9'h024, 16'hA004, 1, 9'h000, 1, 0, 0, 0, 16'h0);
    vecs[17] = mk(1, 9'h025, 16'hA005, 1, 9'h000, 1, 0, 1, 1, 16'h0001);
    vecs[18] = mk(1, 9'h026, 16'hA006, 1, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[19] = mk(1, 9'h027, 16'hA007, 1, 9'h000, 1, 0, 1, 0, 16'h0);
    vecs[20] = mk(1, 9'h028, 16'hA008, 1, 9'h000, 0, 1, 1, 0, 16'h0);
    vecs[21] = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 0, 16'h0);
    vecs[22] = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 1, 16'h0001);
    // Read-after-write on the top address.
    vecs[23] = mk(1, 9'h1FF, 16'hBEEF, 0, 9'h000, 1, 0, 0, 0, 16'h0);
    vecs[24] = mk(0, 9'h000, 16'h0000, 1, 9'h1FF, 0, 1, 1, 0, 16'h0);
    vecs[25] = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 0, 16'h0);
    vecs[26] = mk(0, 9'h000, 16'h0000, 0, 9'h000, 0, 0, 0, 1, 16'hBEEF);

    // Reset held 3 cycles with both requests active.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ack", rd_ack, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_count", wr_count, 0);
    end

    run_vecs(0, 10);
    chk("load_wr_count", wr_count, 4);
    run_vecs(11, 22);
    chk("burst_wr_count", wr_count, 12);
    run_vecs(23, 26);
    chk("raw_wr_count", wr_count, 13);

    // Reset in the cycle after a read grant drops that read.
    @(posedge CLK); #1;
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 9'h001;
    @(negedge CLK);
    chk("midrst_rd_ack", rd_ack, 1);
    @(posedge CLK); #1;
    rd_req = 1'b0; rst = 1'b1;
    @(negedge CLK);
    chk("midrst_ack_in_rst", rd_ack, 0);
    @(posedge CLK); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("midrst_no_rd_valid", rd_valid, 0);
      @(posedge CLK); #1;
    end
    chk("midrst_wr_count", wr_count, 0);
    rd_req = 1'b1; rd_addr = 9'h000;
    @(negedge CLK);
    chk("post_rst_rd_ack", rd_ack, 1);
    @(posedge CLK); #1;
    rd_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge CLK);
      if (rd_valid) begin
        got = 1'b1;
        chk("post_rst_latency", k, 1);
        chk("post_rst_rd_data", rd_data, 16'h0001);
      end else begin
        @(posedge CLK); #1;
      end
    end
    if (!got) chk("post_rst_timeout", 0, 1);

    // 300 writes: count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      wr_valid = 1'b1; wr_addr = 9'(9'h040 + (i % 64)); wr_data = 16'(i);
      @(negedge CLK);
      chk("sat_wr_ready", wr_ready, 1);
      chk($sformatf("sat_wr_count_%0d", i), wr_count, (i > 255) ? 255 : i);
    end
    @(posedge CLK); #1;
    wr_valid = 1'b0;
    @(negedge CLK);
    chk("sat_final_wr_count", wr_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
